// File: rtl/io_input_ctrl.sv
// Memory-mapped controller for two switch/key input ports. Each port is synchronised and
// debounced, and a new value latches a change flag that can raise an interrupt.
module io_input_ctrl #(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             io_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port0,
    input  logic [WIDTH-1:0] in_port1,
    input  logic [31:0]      addr,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [31:0]      io_wdata,
    output logic [31:0]      io_read_data,
    output logic             irq
);

    localparam logic [5:0] AddrData0  = 6'h30;
    localparam logic [5:0] AddrData1  = 6'h31;
    localparam logic [5:0] AddrStatus = 6'h32;
    localparam logic [5:0] AddrCtrl   = 6'h33;

    logic [WIDTH-1:0] pins   [2];
    logic [WIDTH-1:0] stable [2];
    logic [1:0]       chg;
    logic [1:0]       ie;
    logic             stat_clr;
    logic             ctrl_wr;

    assign pins[0]  = in_port0;
    assign pins[1]  = in_port1;
    assign stat_clr = io_rd && (addr[7:2] == AddrStatus);
    assign ctrl_wr  = io_wr && (addr[7:2] == AddrCtrl);

    for (genvar p = 0; p < 2; p++) begin : g_port
        typedef enum logic {StIdle, StCount} state_e;

        state_e           state_q;
        logic [WIDTH-1:0] s1_q, s2_q, cand_q, stable_q;
        logic [CNT_W-1:0] cnt_q;
        logic             chg_q;

        always_ff @(posedge io_clk) begin
            if (reset) begin
                state_q  <= StIdle;
                s1_q     <= '0;
                s2_q     <= '0;
                cand_q   <= '0;
                stable_q <= '0;
                cnt_q    <= '0;
                chg_q    <= 1'b0;
            end else begin
                s1_q <= pins[p];
                s2_q <= s1_q;
                // A qualifying value below overrides this, so a set never gets lost to a read
                if (stat_clr) chg_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (s2_q != stable_q) begin
                            cand_q  <= s2_q;
                            cnt_q   <= CNT_W'(1);
                            state_q <= StCount;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StCount: begin
                        if (s2_q == stable_q) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else if (s2_q != cand_q) begin
                            cand_q <= s2_q;
                            cnt_q  <= CNT_W'(1);
                        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            stable_q <= cand_q;
                            chg_q    <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end

        assign stable[p] = stable_q;
        assign chg[p]    = chg_q;
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            ie  <= 2'b00;
            irq <= 1'b0;
        end else begin
            if (ctrl_wr) ie <= io_wdata[1:0];
            irq <= |(chg & ie);
        end
    end

    always_comb begin
        io_read_data = 32'h0;
        case (addr[7:2])
            AddrData0:  io_read_data = 32'(stable[0]);
            AddrData1:  io_read_data = 32'(stable[1]);
            AddrStatus: io_read_data = {30'b0, chg};
            AddrCtrl:   io_read_data = {30'b0, ie};
            default:    io_read_data = 32'h0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{addr[31:8], addr[1:0], io_wdata[31:2]};

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl: register-read vectors go through a scoreboard queue,
// with hand-timed sequences for debounce latency, read-to-clear and reset corner cases.
module tb_io_input_ctrl;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [4:0]  in_port0, in_port1;
    logic [31:0] addr, io_wdata, io_read_data;
    logic        io_rd, io_wr, irq;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[5];

    io_input_ctrl #(.WIDTH(5), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .io_clk       (io_clk),
        .reset        (reset),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .addr         (addr),
        .io_rd        (io_rd),
        .io_wr        (io_wr),
        .io_wdata     (io_wdata),
        .io_read_data (io_read_data),
        .irq          (irq)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Inputs always change 1 time unit after a rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    // Combinational read without strobe: push expectation, drive address, pop and compare.
    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        sb_q.push_back('{exp: exp, name: name});
        addr = a;
        #1;
        e = sb_q.pop_front();
        chk(e.name, io_read_data, e.exp);
    endtask

    // Strobed read: the value is compared before the edge that carries the read side effect.
    task automatic rd_strobe(input logic [31:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        sb_q.push_back('{exp: exp, name: name});
        addr  = a;
        io_rd = 1'b1;
        #1;
        e = sb_q.pop_front();
        chk(e.name, io_read_data, e.exp);
        tick();
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr     = a;
        io_wdata = d;
        io_wr    = 1'b1;
        tick();
        io_wr = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_port0 = '0;
        in_port1 = '0;
        addr     = '0;
        io_wdata = '0;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();

        // Reset state: every mapped and one unmapped address read zero.
        tbl[0] = '{a: 32'hC0, exp: 32'h0, name: "rst_data0"};
        tbl[1] = '{a: 32'hC4, exp: 32'h0, name: "rst_data1"};
        tbl[2] = '{a: 32'hC8, exp: 32'h0, name: "rst_status"};
        tbl[3] = '{a: 32'hCC, exp: 32'h0, name: "rst_ctrl"};
        tbl[4] = '{a: 32'hD0, exp: 32'h0, name: "rst_unmapped"};
        for (int i = 0; i < 5; i++) peek(tbl[i].a, tbl[i].exp, tbl[i].name);
        chk("rst_irq", 32'(irq), 32'h0);

        // Port0 0 -> 15: invisible through E5, visible from E6.
        in_port0 = 5'h15;
        for (int k = 1; k <= 5; k++) begin
            tick();
            peek(32'hC0, 32'h0, $sformatf("p0_latency_e%0d", k));
        end
        tick();
        peek(32'hC0, 32'h15, "p0_e6");
        peek(32'hC8, 32'h1, "status_p0");
        chk("irq_masked", 32'(irq), 32'h0);

        // Two-cycle glitch on port1 is rejected.
        in_port1 = 5'h03;
        tick(2);
        in_port1 = 5'h00;
        tick(8);
        peek(32'hC4, 32'h0, "glitch_data1");
        peek(32'hC8, 32'h1, "glitch_status");
        peek(32'hFFFF_FFC0, 32'h15, "upper_addr_ignored");

        // Read-to-clear, then a write to a non-CTRL address is ignored.
        rd_strobe(32'hC8, 32'h1, "clr_read");
        peek(32'hC8, 32'h0, "clr_after");
        wr(32'hC8, 32'h3);
        peek(32'hCC, 32'h0, "wr_other_ignored");

        // Enable interrupts; port1 -> 1F raises chg1 at E6 and irq one edge later.
        wr(32'hCC, 32'h3);
        peek(32'hCC, 32'h3, "ctrl_rb");
        in_port1 = 5'h1F;
        tick(6);
        peek(32'hC4, 32'h1F, "p1_data");
        peek(32'hC8, 32'h2, "p1_status");
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_rise", 32'(irq), 32'h1);
        rd_strobe(32'hC8, 32'h2, "irq_clr_read");
        chk("irq_hold_clr_edge", 32'(irq), 32'h1);
        peek(32'hC8, 32'h0, "irq_clr_status");
        tick();
        chk("irq_drop", 32'(irq), 32'h0);

        // STATUS read on the same edge port0 qualifies: old flags returned, set wins.
        in_port1 = 5'h00;
        tick(7);
        chk("irq_pre_collide", 32'(irq), 32'h1);
        in_port0 = 5'h0A;
        tick(5);
        rd_strobe(32'hC8, 32'h2, "collide_read");
        peek(32'hC0, 32'h0A, "collide_data0");
        peek(32'hC8, 32'h1, "collide_status");
        chk("collide_irq0", 32'(irq), 32'h1);
        tick();
        chk("collide_irq1", 32'(irq), 32'h1);

        // Reset at cnt=2 while port0 is held at 0A; re-qualified after reset.
        in_port0 = 5'h00;
        tick(7);
        rd_strobe(32'hC8, 32'h1, "pre_rst_clear");
        peek(32'hC0, 32'h0, "pre_rst_data0");
        in_port0 = 5'h0A;
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        peek(32'hC0, 32'h0, "rst_mid_data0");
        peek(32'hCC, 32'h0, "rst_mid_ctrl");
        chk("rst_mid_irq", 32'(irq), 32'h0);
        tick(5);
        peek(32'hC0, 32'h0, "requal_e5");
        tick();
        peek(32'hC0, 32'h0A, "requal_e6");
        peek(32'hC8, 32'h1, "requal_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
